// File: rtl/vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter
//
// Shares one single-port synchronous framebuffer SRAM (160x120, 8 bpp RGB332)
// between display scan-out and a pixel-writer port. Each framebuffer pixel
// covers a 4x4 block of the 640x480 display, so scan-out needs one SRAM read
// every 4 clocks during active lines. Every other SRAM cycle goes to the
// writer.
//
// Ports
//   clk_25     in   pixel clock
//   reset_n    in   synchronous active-low reset
//   h_count    in   [9:0]  horizontal counter from the timing generator
//   v_count    in   [9:0]  vertical counter from the timing generator
//   wr_req     in   writer request; wr_addr/wr_data stable until wr_ack
//   wr_addr    in   [14:0] framebuffer word address (y*160+x)
//   wr_data    in   [7:0]  pixel value
//   wr_ack     out  one-cycle completion pulse
//   wr_err     out  valid with wr_ack; 1 = address out of range, not written
//   mem_en     out  SRAM enable (combinational)
//   mem_we     out  SRAM write enable (combinational)
//   mem_addr   out  [14:0] SRAM address (combinational)
//   mem_wdata  out  [7:0]  SRAM write data (combinational)
//   mem_rdata  in   [7:0]  SRAM read data, valid the cycle after the read
//   pixel_out  out  [7:0]  registered display pixel, 0 outside active video
// ---------------------------------------------------------------------------
module vga_fb_arbiter #(
  parameter int H_ACT_START   = 160,
  parameter int V_ACT_START   = 41,
  parameter int FB_W          = 160,
  parameter int FB_WORDS      = 19200,
  parameter bit WR_ONLY_BLANK = 1'b0
) (
  input  logic        clk_25,
  input  logic        reset_n,
  input  logic [9:0]  h_count,
  input  logic [9:0]  v_count,
  input  logic        wr_req,
  input  logic [14:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ack,
  output logic        wr_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  pixel_out
);

  localparam int FB_H = FB_WORDS / FB_W;

  // Active video window on the display counters.
  localparam logic [9:0] V_FIRST = 10'(V_ACT_START);
  localparam logic [9:0] V_LAST  = 10'(V_ACT_START + 4 * FB_H - 1);
  localparam logic [9:0] H_FIRST = 10'(H_ACT_START);
  localparam logic [9:0] H_LAST  = 10'(H_ACT_START + 4 * FB_W - 1);

  // Fetches run 4 clocks ahead of display so the word is in fetch_buf
  // before its 4-pixel block starts.
  localparam logic [9:0] SLOT_FIRST = 10'(H_ACT_START - 4);
  localparam logic [9:0] SLOT_LAST  = 10'(H_ACT_START + 4 * FB_W - 8);
  localparam logic [9:0] CAP_FIRST  = 10'(H_ACT_START - 3);
  localparam logic [9:0] CAP_LAST   = 10'(H_ACT_START + 4 * FB_W - 7);

  localparam logic [14:0] FB_LIMIT = 15'(FB_WORDS);

  typedef enum logic {
    S_IDLE,
    S_ACK
  } wr_state_t;

  wr_state_t r_state;
  wr_state_t w_next;

  logic        r_err;
  logic [7:0]  r_fetch_buf;
  logic [7:0]  r_pixel;

  logic        w_v_act;
  logic        w_h_act;
  logic        w_slot;
  logic        w_capture;
  logic        w_wr_window;
  logic        w_oob;
  logic        w_grant;
  logic [9:0]  w_v_off;
  logic [9:0]  w_h_off;
  logic [14:0] w_fb_y;
  logic [14:0] w_fb_x;
  logic [14:0] w_fetch_addr;

  // Window decode. Out-of-range counter values (h=800, v>=521) fall outside
  // every compare and are naturally inactive.
  assign w_v_act   = (v_count >= V_FIRST) && (v_count <= V_LAST);
  assign w_h_act   = (h_count >= H_FIRST) && (h_count <= H_LAST);
  assign w_slot    = w_v_act && (h_count >= SLOT_FIRST) && (h_count <= SLOT_LAST)
                     && (h_count[1:0] == 2'b00);
  assign w_capture = w_v_act && (h_count >= CAP_FIRST) && (h_count <= CAP_LAST)
                     && (h_count[1:0] == 2'b01);

  // Framebuffer coordinates of the word fetched in this slot.
  assign w_v_off = v_count - V_FIRST;
  assign w_h_off = h_count - SLOT_FIRST;
  assign w_fb_y  = {5'd0, w_v_off} >> 2;
  assign w_fb_x  = {5'd0, w_h_off} >> 2;

  // y*160 as two shifts; the framebuffer row pitch is fixed at 160 words.
  assign w_fetch_addr = (w_fb_y << 7) + (w_fb_y << 5) + w_fb_x;

  assign w_wr_window = !WR_ONLY_BLANK || !w_v_act;
  assign w_oob       = (wr_addr >= FB_LIMIT);

  // NOTE: every signal driven here gets a default first so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    w_next    = r_state;
    w_grant   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    // Display fetch owns the SRAM in its slot regardless of the writer.
    if (w_slot) begin
      mem_en   = 1'b1;
      mem_addr = w_fetch_addr;
    end

    case (r_state)
      S_IDLE: begin
        // Grant is blocked while reset is asserted so a write presented in
        // the reset cycle never reaches the SRAM; the writer keeps wr_req
        // high and is granted again once reset releases.
        if (wr_req && !w_slot && w_wr_window && reset_n) begin
          w_grant = 1'b1;
          w_next  = S_ACK;
          if (!w_oob) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
          end
        end
      end
      S_ACK: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk_25) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_err       <= 1'b0;
      r_fetch_buf <= '0;
      r_pixel     <= '0;
    end else begin
      r_state <= w_next;
      r_err   <= w_grant && w_oob;

      // Read data from the slot one cycle earlier is valid now.
      if (w_capture) begin
        r_fetch_buf <= mem_rdata;
      end

      // Load a new word at the start of each 4-pixel block and hold it for
      // the other three; blank outside active video.
      if (w_v_act && w_h_act) begin
        if (h_count[1:0] == 2'b00) begin
          r_pixel <= r_fetch_buf;
        end
      end else begin
        r_pixel <= '0;
      end
    end
  end

  assign wr_ack    = (r_state == S_ACK);
  assign wr_err    = r_err;
  assign pixel_out = r_pixel;

endmodule
